// File: rtl/memcontrol_pkg.sv
// Shared types for the two-port memory controller and its bench.
package memcontrol_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StReadReq  = 3'd1,
      StWriteReq = 3'd2,
      StWait     = 3'd3,
      StDone     = 3'd4
   } state_t;

   typedef enum logic {
      GrantInstr = 1'b0,
      GrantData  = 1'b1
   } grant_t;

   // The port that did not win last time; used for round-robin ties.
   function automatic grant_t other_port(grant_t g);
      return (g == GrantInstr) ? GrantData : GrantInstr;
   endfunction

endpackage

// File: rtl/memcontrol_arb_if.sv
// Fetch port, load/store port and shared bus of the memory controller.
interface memcontrol_arb_if
   import memcontrol_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();
   logic                  i_req;
   logic [ADDR_W-1:0]     i_addr;
   logic                  i_ready;
   logic                  i_err;
   logic [DATA_W-1:0]     i_rdata;
   logic                  d_read;
   logic                  d_write;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic [DATA_W/8-1:0]   d_be;
   logic                  d_ready;
   logic                  d_err;
   logic [DATA_W-1:0]     d_rdata;
   logic [ADDR_W-1:0]     bus_addr;
   logic [DATA_W-1:0]     bus_wdata;
   logic [DATA_W/8-1:0]   bus_be;
   logic                  bus_read;
   logic                  bus_write;
   logic [DATA_W-1:0]     bus_rdata;
   logic                  bus_full;
   state_t                state;

   // Environment side: CPU requesters plus the system bus.
   modport master (
      output i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_be, bus_rdata, bus_full,
      input  i_ready, i_err, i_rdata, d_ready, d_err, d_rdata,
      input  bus_addr, bus_wdata, bus_be, bus_read, bus_write, state
   );

   // Controller side.
   modport slave (
      input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_be, bus_rdata, bus_full,
      output i_ready, i_err, i_rdata, d_ready, d_err, d_rdata,
      output bus_addr, bus_wdata, bus_be, bus_read, bus_write, state
   );
endinterface

// File: rtl/memcontrol_arbiter.sv
// Grant selection between fetch and data ports, with the last-grant flop.
module memcontrol_arbiter
   import memcontrol_pkg::*;
#(
   parameter bit DATA_PRIO = 1'b1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_fetch_req,
   input  logic   i_data_rd,
   input  logic   i_data_wr,
   input  logic   i_grant_en,
   output logic   o_valid,
   output grant_t o_grant
);
   grant_t r_last_grant;
   logic   w_data_req;

   assign w_data_req = i_data_rd | i_data_wr;

   // Pick a winner; on a tie either data always wins or the other port wins.
   always_comb begin
      o_valid = i_fetch_req | w_data_req;
      o_grant = GrantInstr;
      if (w_data_req && i_fetch_req) begin
         o_grant = DATA_PRIO ? GrantData : other_port(r_last_grant);
      end else if (w_data_req) begin
         o_grant = GrantData;
      end
   end

   // Remember every grant actually taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= GrantInstr;
      end else if (i_grant_en && o_valid) begin
         r_last_grant <= o_grant;
      end
   end
endmodule

// File: rtl/memcontrol_arb.sv
// Two-port memory controller: arbitrates fetch and load/store onto one bus.
module memcontrol_arb
   import memcontrol_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TIMEOUT   = 15,
   parameter bit          DATA_PRIO = 1'b1
) (
   input logic             clk,
   input logic             rst,
   memcontrol_arb_if.slave ctrl
);
   localparam int unsigned     BE_W     = DATA_W / 8;
   localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t              r_state, w_next;
   grant_t              r_cur;
   logic                r_is_read;
   logic                r_err;
   logic [CNT_W-1:0]    r_cnt;
   logic [ADDR_W-1:0]   r_bus_addr;
   logic [DATA_W-1:0]   r_bus_wdata;
   logic [BE_W-1:0]     r_bus_be;
   logic [DATA_W-1:0]   r_i_rdata;
   logic [DATA_W-1:0]   r_d_rdata;
   logic                w_gnt_valid;
   grant_t              w_gnt;
   logic                w_in_idle;
   logic                w_timeout;

   assign w_in_idle = (r_state == StIdle);
   // Last busy cycle allowed in WAIT; the transaction ends with an error.
   assign w_timeout = (r_state == StWait) && ctrl.bus_full && (r_cnt == CNT_LAST);

   memcontrol_arbiter #(
      .DATA_PRIO (DATA_PRIO)
   ) u_arbiter (
      .clk         (clk),
      .rst         (rst),
      .i_fetch_req (ctrl.i_req),
      .i_data_rd   (ctrl.d_read),
      .i_data_wr   (ctrl.d_write),
      .i_grant_en  (w_in_idle),
      .o_valid     (w_gnt_valid),
      .o_grant     (w_gnt)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_next;
   end

   // Next-state logic; stores with no enabled bytes skip the bus entirely.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_gnt_valid) begin
               if (w_gnt == GrantInstr || !ctrl.d_write) w_next = StReadReq;
               else if (ctrl.d_be == '0)                w_next = StDone;
               else                                     w_next = StWriteReq;
            end
         end
         StReadReq, StWriteReq: w_next = StWait;
         StWait:                if (!ctrl.bus_full || w_timeout) w_next = StDone;
         StDone:                w_next = StIdle;
         default:               w_next = StIdle;
      endcase
   end

   // Bus latches, wait counter and per-port read data; rdata lands as DONE is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cur       <= GrantInstr;
         r_is_read   <= 1'b0;
         r_err       <= 1'b0;
         r_cnt       <= '0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_be    <= '0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_gnt_valid) begin
                  r_cur <= w_gnt;
                  r_err <= 1'b0;
                  if (w_gnt == GrantInstr) begin
                     r_bus_addr  <= ctrl.i_addr;
                     r_bus_wdata <= '0;
                     r_bus_be    <= '1;
                     r_is_read   <= 1'b1;
                  end else begin
                     r_bus_addr  <= ctrl.d_addr;
                     r_bus_wdata <= ctrl.d_wdata;
                     r_bus_be    <= ctrl.d_be;
                     r_is_read   <= !ctrl.d_write;
                  end
               end
            end
            StReadReq, StWriteReq: r_cnt <= '0;
            StWait: begin
               if (!ctrl.bus_full) begin
                  if (r_is_read) begin
                     if (r_cur == GrantInstr) r_i_rdata <= ctrl.bus_rdata;
                     else                     r_d_rdata <= ctrl.bus_rdata;
                  end
               end else if (w_timeout) begin
                  r_err <= 1'b1;
                  if (r_is_read) begin
                     if (r_cur == GrantInstr) r_i_rdata <= '0;
                     else                     r_d_rdata <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from the registered state.
   always_comb begin
      ctrl.bus_read  = (r_state == StReadReq);
      ctrl.bus_write = (r_state == StWriteReq);
      ctrl.i_ready   = (r_state == StDone) && (r_cur == GrantInstr);
      ctrl.d_ready   = (r_state == StDone) && (r_cur == GrantData);
      ctrl.i_err     = ctrl.i_ready && r_err;
      ctrl.d_err     = ctrl.d_ready && r_err;
      ctrl.bus_addr  = r_bus_addr;
      ctrl.bus_wdata = r_bus_wdata;
      ctrl.bus_be    = r_bus_be;
      ctrl.i_rdata   = r_i_rdata;
      ctrl.d_rdata   = r_d_rdata;
      ctrl.state     = r_state;
   end
endmodule

// File: doc/memcontrol_arb.md
Name: memcontrol_arb

Overview:
Parametrised two-port memory controller for the RV32I core. It arbitrates an instruction-fetch port and a data load/store port onto a single shared memory bus, with a configurable arbitration mode. It adds byte-enabled stores, bus-busy timeout with error reporting, and a ready/error handshake per port. It sits between the CPU's fetch/memory stages and the system bus; it supersedes the single-path memcontrol.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; must be a multiple of 8
TIMEOUT, 15, maximum cycles in WAIT with bus_full high before an error is reported (>=1)
DATA_PRIO, 1, 1 = data port always wins a tie; 0 = round-robin between ports

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
i_req  in  1  fetch request, level; held until i_ready
i_addr  in  ADDR_W  fetch address
i_ready  out  1  one-cycle pulse: fetch complete
i_err  out  1  valid with i_ready: fetch timed out
i_rdata  out  DATA_W  fetched word; held until the next fetch completes
d_read  in  1  load request, level
d_write  in  1  store request, level
d_addr  in  ADDR_W  load/store address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  store byte enables
d_ready  out  1  one-cycle pulse: load/store complete
d_err  out  1  valid with d_ready: timeout
d_rdata  out  DATA_W  load data; held until the next load completes
bus_addr  out  ADDR_W  registered bus address
bus_wdata  out  DATA_W  registered bus write data
bus_be  out  DATA_W/8  registered byte enables
bus_read  out  1  one-cycle read strobe
bus_write  out  1  one-cycle write strobe
bus_rdata  in  DATA_W  bus read data, valid when bus_full is low in WAIT
bus_full  in  1  bus busy
state  out  3  current state_t, for debug and the bench

Behaviour:
- Reset: all outputs 0, state=IDLE, timeout counter 0, last_grant=INSTR. Reset mid-transaction drops that transaction; no ready pulse is issued.
- States: IDLE, READ_REQ, WRITE_REQ, WAIT, DONE.
- IDLE:
  - Samples requests each cycle. The winner's address, wdata and be are latched into the bus_* registers.
  - Instruction fetch: bus_be = all ones.
  - Data load: bus_be = d_be.
  - Next state: a read goes to READ_REQ; a store goes to WRITE_REQ.
- Tie-break between ports: if DATA_PRIO=1, data wins. If DATA_PRIO=0, the port not in last_grant wins. last_grant updates on every grant.
- d_read and d_write both high: treated as a store.
- Store with d_be==0: no bus strobe; IDLE goes directly to DONE with d_err=0.
- READ_REQ / WRITE_REQ: bus_read or bus_write is high for exactly one cycle; next state is WAIT.
- WAIT:
  - bus_full=0: capture bus_rdata for reads, then go to DONE.
  - bus_full=1: increment the counter.
  - Counter reaches TIMEOUT: go to DONE with err=1; read data is forced to 0.
  - The counter clears on entry to WAIT.
- DONE: pulse the granted port's ready (and err) for one cycle and update its rdata register, then return to IDLE. The requester must drop or change its request in the cycle after ready.
- Minimum latency: request seen in IDLE at cycle N, strobe at N+1, WAIT at N+2, ready at N+3. Back-to-back transactions therefore complete every 4 cycles.
- A request asserted while another transaction is in flight is held pending. It is never lost.
- Addresses pass through unmodified; alignment is the bus's concern.

Decomposition:
- memcontrol_pkg holds the state_t enum (IDLE=0, READ_REQ=1, WRITE_REQ=2, WAIT=3, DONE=4) and the grant_t enum (INSTR, DATA). The bench shares both.
- One sub-module, memcontrol_arbiter: combinational grant from i_req/d_read/d_write/last_grant/DATA_PRIO plus the last_grant flop.

Test Plan:
- Reset with i_req=1 and d_read=1 held high -> all outputs 0, state=IDLE. After release: fetch of 0x100 with bus_rdata=0xDEADBEEF and bus_full=0 -> bus_read at N+1, i_ready with i_rdata=0xDEADBEEF at N+3.
- Store d_addr=0x2000, d_wdata=0x12345678, d_be=4'b0011, bus_full=0 -> bus_write for one cycle with bus_be=0011, d_ready at N+3, d_err=0.
- Simultaneous i_req and d_read, DATA_PRIO=1 -> data served first, fetch served next. With DATA_PRIO=0, two consecutive ties -> grants alternate starting with DATA.
- bus_full held high for 20 cycles, TIMEOUT=15 -> d_ready and d_err pulse after 15 WAIT cycles, d_rdata=0, state returns to IDLE.
- Store with d_be=0 -> no bus_write, d_ready at N+1.
- rst asserted in WAIT during a fetch -> state=IDLE immediately, no i_ready. The next fetch completes normally.
